icache_ctrl: RTL and testbench
==============================

Name: icache_ctrl

Overview:
- Direct-mapped, word-addressed instruction cache that sits directly downstream of the program counter.
- Consumes `pc_addr` and returns the instruction word combinationally on a hit.
- On a miss, asserts `cache_stall` back to the PC and pipeline, then fills a whole line from instruction memory over a req/ack handshake.
- Sole producer of `cache_stall` in the fetch path.

Parameters:
- BITS, 32, word width and address width (word addresses, PC increments by 1).
- LINES, 16, number of cache lines; power of 2, >=2.
- WORDS, 4, words per line; power of 2, >=2.

Ports:
- clk  input  1  system clock
- rst_  input  1  system reset, asynchronous, active low
- pc_addr  input  BITS  current fetch address from the PC
- flush  input  1  invalidate all lines (single-cycle pulse)
- instr  output  BITS  fetched instruction; 0 when not a valid hit
- cache_stall  output  1  fetch not satisfied this cycle; PC must hold
- mem_req  output  1  line-fill request to instruction memory
- mem_addr  output  BITS  word address of the word currently requested
- mem_rdata  input  BITS  memory read data, valid when mem_ack=1
- mem_ack  input  1  one word delivered this cycle

Behaviour:
- Address split:
  - OFF = log2(WORDS) LSBs.
  - IDX = next log2(LINES) bits.
  - TAG = remaining MSBs.
- Hit (combinational) = state==LOOKUP && valid[IDX] && tag[IDX]==TAG.
  - instr = hit ? data[IDX][OFF] : 0.
  - cache_stall = !hit.
- Reset (rst_ low, asynchronous):
  - state=LOOKUP; all valid bits cleared; mem_req=0; mem_addr=0; fill counter=0; miss address reg=0.
  - Data and tag arrays are not reset.
  - Out of reset: instr=0 and cache_stall=1, because pc 0 misses.
- States: LOOKUP, FILL.
- LOOKUP on miss:
  - Latch base = {TAG, IDX, OFF=0} into the miss address reg.
  - mem_req<=1, mem_addr<=base, count<=0, state<=FILL.
- FILL:
  - mem_req held at 1 and mem_addr held stable until mem_ack.
  - On each mem_ack: data[miss IDX][count]<=mem_rdata; count++; mem_addr<=base+count+1.
  - mem_ack with mem_req=0 is ignored.
- Last word (count==WORDS-1 with mem_ack):
  - tag[IDX]<=miss TAG; valid[IDX]<=1 unless a flush occurred during this fill.
  - mem_req<=0, mem_addr<=0, state<=LOOKUP.
- Latency:
  - Miss detected in cycle N; with mem_ack every cycle, ack cycles are N+1..N+WORDS.
  - Hit with cache_stall=0 in cycle N+WORDS+1.
  - Minimum miss penalty is WORDS+1 stall cycles.
- pc_addr changes during FILL are ignored:
  - The fill completes for the latched address.
  - LOOKUP then re-evaluates the current pc_addr.
- flush:
  - In LOOKUP: all valid bits cleared at the clock edge, so the current hit is lost the next cycle.
  - In FILL: all valid bits cleared and a flush-pending flag set. The fill runs to completion, but the line is not validated, giving a re-miss in LOOKUP. The flag clears on return to LOOKUP.
- Line replacement: a miss to an occupied index overwrites it (conflict eviction).
- Partial data: words written in an unfinished fill are not visible until valid is set.
- Reset mid-fill: immediate abort; mem_req=0 and the line stays invalid.
- Wrap-around: base+count never carries out of the line, because OFF bits of base are 0.

Decomposition:
- Package icache_pkg: state enum {LOOKUP, FILL}, derived localparams OFF_BITS/IDX_BITS/TAG_BITS, address field helper functions.
- Sub-module icache_array: valid/tag/data storage, combinational read at IDX/OFF, single write port, valid clear-all. The FSM, counter and handshake stay in icache_ctrl.

Test Plan:
- Reset then pc_addr=0, memory returns 0x11,0x22,0x33,0x44 with ack every cycle:
  - mem_addr 0,1,2,3 and mem_req high for 4 cycles.
  - cache_stall=1 for 5 cycles, then instr=0x11 with stall=0.
  - pc 1..3 give 0x22,0x33,0x44 with no stall.
- Ack gaps (ack on alternate cycles):
  - mem_addr holds each value until acked.
  - Line valid only after the 4th ack.
- Conflict eviction (defaults):
  - Fill pc=0, then pc=64 (same IDX 0, new tag): miss and mem_addr 64..67.
  - pc=0 afterwards misses again.
- Flush:
  - After a valid line at pc=8, flush: next cycle stall=1 and a refill from 8.
  - Flush asserted at 2nd ack of a fill: fill completes (4 acks), then re-miss and a second fill from the same base.
- Reset mid-fill after 2 acks: mem_req=0 immediately, then a fresh miss from pc=0 with mem_addr=0.
- pc_addr changed from 4 to 20 during a fill of 4:
  - Fill of base 4 completes.
  - Then a miss for 20 (base 20) is issued.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types, default geometry and address-field helpers for the instruction cache.
package icache_pkg;

  typedef enum logic {
    LOOKUP = 1'b0,
    FILL   = 1'b1
  } state_e;

  localparam int unsigned DEF_BITS  = 32;
  localparam int unsigned DEF_LINES = 16;
  localparam int unsigned DEF_WORDS = 4;

  localparam int unsigned OFF_BITS = $clog2(DEF_WORDS);
  localparam int unsigned IDX_BITS = $clog2(DEF_LINES);
  localparam int unsigned TAG_BITS = DEF_BITS - IDX_BITS - OFF_BITS;

  // Extract a width-bit field starting at bit lsb; callers size-cast the result.
  function automatic logic [63:0] addr_field(input logic [63:0] a,
                                             input int unsigned lsb,
                                             input int unsigned width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return (a >> lsb) & mask;
  endfunction

  function automatic logic [63:0] line_base(input logic [63:0] a,
                                            input int unsigned off_bits);
    return (a >> off_bits) << off_bits;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read port, one write port, valid clear-all.
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned BITS  = DEF_BITS,
  parameter int unsigned LINES = DEF_LINES,
  parameter int unsigned WORDS = DEF_WORDS,
  parameter int unsigned IDX_W = $clog2(LINES),
  parameter int unsigned OFF_W = $clog2(WORDS),
  parameter int unsigned TAG_W = BITS - IDX_W - OFF_W
) (
  input  logic             i_clk,
  input  logic             i_rst_,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic [OFF_W-1:0] i_rd_off,
  output logic             o_rd_valid,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic [BITS-1:0]  o_rd_data,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [OFF_W-1:0] i_wr_off,
  input  logic [BITS-1:0]  i_wr_data,
  input  logic             i_tag_we,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_valid_set,
  input  logic             i_clear_all
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [BITS-1:0]  r_data [LINES][WORDS];

  // A set on the same edge as a clear-all wins; the controller never requests both.
  always_ff @(posedge i_clk or negedge i_rst_) begin
    if (!i_rst_) begin
      r_valid <= '0;
    end else begin
      if (i_clear_all) r_valid <= '0;
      if (i_tag_we && i_valid_set) r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en)  r_data[i_wr_idx][i_wr_off] <= i_wr_data;
    if (i_tag_we) r_tag[i_wr_idx] <= i_tag;
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx][i_rd_off];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped word-addressed instruction cache: combinational hit path, line fill over req/ack.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned BITS  = DEF_BITS,
  parameter int unsigned LINES = DEF_LINES,
  parameter int unsigned WORDS = DEF_WORDS
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic [BITS-1:0] pc_addr,
  input  logic            flush,
  output logic [BITS-1:0] instr,
  output logic            cache_stall,
  output logic            mem_req,
  output logic [BITS-1:0] mem_addr,
  input  logic [BITS-1:0] mem_rdata,
  input  logic            mem_ack
);

  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = BITS - IDX_W - OFF_W;

  state_e           r_state, w_state_nx;
  logic             r_mem_req, w_mem_req_nx;
  logic [BITS-1:0]  r_mem_addr, w_mem_addr_nx;
  logic [BITS-1:0]  r_miss_addr, w_miss_addr_nx;
  logic [OFF_W-1:0] r_count, w_count_nx;
  logic             r_flush_pend, w_flush_pend_nx;

  logic [OFF_W-1:0] w_pc_off;
  logic [IDX_W-1:0] w_pc_idx;
  logic [TAG_W-1:0] w_pc_tag;
  logic [BITS-1:0]  w_pc_base;
  logic [IDX_W-1:0] w_miss_idx;
  logic [TAG_W-1:0] w_miss_tag;
  logic [OFF_W-1:0] w_count_inc;

  logic             w_rd_valid;
  logic [TAG_W-1:0] w_rd_tag;
  logic [BITS-1:0]  w_rd_data;
  logic             w_hit;
  logic             w_ack;
  logic             w_last;

  assign w_pc_off    = OFF_W'(addr_field(64'(pc_addr), 0, OFF_W));
  assign w_pc_idx    = IDX_W'(addr_field(64'(pc_addr), OFF_W, IDX_W));
  assign w_pc_tag    = TAG_W'(addr_field(64'(pc_addr), OFF_W + IDX_W, TAG_W));
  assign w_pc_base   = BITS'(line_base(64'(pc_addr), OFF_W));
  assign w_miss_idx  = IDX_W'(addr_field(64'(r_miss_addr), OFF_W, IDX_W));
  assign w_miss_tag  = TAG_W'(addr_field(64'(r_miss_addr), OFF_W + IDX_W, TAG_W));
  assign w_count_inc = r_count + 1'b1;

  assign w_hit  = (r_state == LOOKUP) && w_rd_valid && (w_rd_tag == w_pc_tag);
  assign w_ack  = (r_state == FILL) && r_mem_req && mem_ack;
  assign w_last = w_ack && (r_count == OFF_W'(WORDS - 1));

  icache_array #(
    .BITS  (BITS),
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_array (
    .i_clk       (clk),
    .i_rst_      (rst_),
    .i_rd_idx    (w_pc_idx),
    .i_rd_off    (w_pc_off),
    .o_rd_valid  (w_rd_valid),
    .o_rd_tag    (w_rd_tag),
    .o_rd_data   (w_rd_data),
    .i_wr_en     (w_ack),
    .i_wr_idx    (w_miss_idx),
    .i_wr_off    (r_count),
    .i_wr_data   (mem_rdata),
    .i_tag_we    (w_last),
    .i_tag       (w_miss_tag),
    .i_valid_set (!r_flush_pend && !flush),
    .i_clear_all (flush)
  );

  always_comb begin
    w_state_nx      = r_state;
    w_mem_req_nx    = r_mem_req;
    w_mem_addr_nx   = r_mem_addr;
    w_miss_addr_nx  = r_miss_addr;
    w_count_nx      = r_count;
    w_flush_pend_nx = r_flush_pend;
    case (r_state)
      LOOKUP: begin
        if (!w_hit) begin
          w_miss_addr_nx  = w_pc_base;
          w_mem_req_nx    = 1'b1;
          w_mem_addr_nx   = w_pc_base;
          w_count_nx      = '0;
          w_flush_pend_nx = 1'b0;
          w_state_nx      = FILL;
        end
      end
      FILL: begin
        if (flush) w_flush_pend_nx = 1'b1;
        if (w_last) begin
          w_mem_req_nx    = 1'b0;
          w_mem_addr_nx   = '0;
          w_flush_pend_nx = 1'b0;
          w_state_nx      = LOOKUP;
        end else if (w_ack) begin
          // Base has zero offset bits, so this add never leaves the line.
          w_count_nx    = w_count_inc;
          w_mem_addr_nx = r_miss_addr + BITS'(w_count_inc);
        end
      end
      default: w_state_nx = LOOKUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state      <= LOOKUP;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_miss_addr  <= '0;
      r_count      <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_mem_req    <= w_mem_req_nx;
      r_mem_addr   <= w_mem_addr_nx;
      r_miss_addr  <= w_miss_addr_nx;
      r_count      <= w_count_nx;
      r_flush_pend <= w_flush_pend_nx;
    end
  end

  assign instr       = w_hit ? w_rd_data : '0;
  assign cache_stall = !w_hit;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: directed scenarios with literal expectations plus randomized traffic vs a line-level model.
module tb_icache_ctrl;

  localparam int unsigned BITS  = 32;
  localparam int unsigned LINES = 16;
  localparam int unsigned WORDS = 4;

  logic            clk = 1'b0;
  logic            rst_;
  logic [BITS-1:0] pc_addr;
  logic            flush;
  logic [BITS-1:0] instr;
  logic            cache_stall;
  logic            mem_req;
  logic [BITS-1:0] mem_addr;
  logic [BITS-1:0] mem_rdata;
  logic            mem_ack;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  icache_ctrl #(
    .BITS  (BITS),
    .LINES (LINES),
    .WORDS (WORDS)
  ) dut (
    .clk         (clk),
    .rst_        (rst_),
    .pc_addr     (pc_addr),
    .flush       (flush),
    .instr       (instr),
    .cache_stall (cache_stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: words 0..3 are 0x11,0x22,0x33,0x44, the rest a hash.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a < 4) return 32'h11 * (a + 1);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  assign mem_rdata = mem_fn(mem_addr);

  // Line-level reference model
  bit          m_valid [LINES];
  logic [31:0] m_tag   [LINES];
  logic [31:0] m_data  [LINES][WORDS];
  bit          m_filling;
  bit          m_fp;
  logic [31:0] m_base;
  int unsigned m_cnt;

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (a / WORDS) % LINES;
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (WORDS * LINES);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return !m_filling && m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
  endfunction

  task automatic model_reset();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_filling = 1'b0;
    m_fp      = 1'b0;
    m_cnt     = 0;
    m_base    = '0;
  endtask

  task automatic model_step();
    bit h;
    int unsigned i;
    if (!rst_) return;
    h = m_hit(pc_addr);
    if (!m_filling) begin
      if (flush) foreach (m_valid[k]) m_valid[k] = 1'b0;
      if (!h) begin
        m_filling = 1'b1;
        m_base    = pc_addr - (pc_addr % WORDS);
        m_cnt     = 0;
        m_fp      = 1'b0;
      end
    end else begin
      if (flush) begin
        foreach (m_valid[k]) m_valid[k] = 1'b0;
        m_fp = 1'b1;
      end
      if (mem_ack) begin
        i = idx_of(m_base);
        m_data[i][m_cnt] = mem_fn(m_base + m_cnt);
        m_cnt++;
        if (m_cnt == WORDS) begin
          m_tag[i]   = tag_of(m_base);
          m_valid[i] = !m_fp;
          m_filling  = 1'b0;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      logic [31:0] p;
      bit          h;
      p = pc_addr;
      h = m_hit(p);
      check("model.instr", instr, h ? m_data[idx_of(p)][p % WORDS] : 32'h0);
      check("model.stall", {31'b0, cache_stall}, {31'b0, !h});
      check("model.mem_req", {31'b0, mem_req}, {31'b0, m_filling});
      check("model.mem_addr", mem_addr, m_filling ? m_base + m_cnt : 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_    = 1'b0;
    pc_addr = '0;
    flush   = 1'b0;
    mem_ack = 1'b0;
    model_reset();
    started = 1'b1;
    cycles(2);
    settle();
    check("reset.stall", {31'b0, cache_stall}, 32'd1);
    check("reset.instr", instr, 32'h0);
    check("reset.req", {31'b0, mem_req}, 32'd0);
    check("reset.addr", mem_addr, 32'h0);

    // Cold miss at pc 0, ack every cycle
    rst_    = 1'b1;
    mem_ack = 1'b1;
    settle();
    check("t1.miss_stall", {31'b0, cache_stall}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(); settle();
      check("t1.fill_req", {31'b0, mem_req}, 32'd1);
      check("t1.fill_addr", mem_addr, 32'(i));
      check("t1.fill_stall", {31'b0, cache_stall}, 32'd1);
    end
    step(); settle();
    check("t1.hit_stall", {31'b0, cache_stall}, 32'd0);
    check("t1.instr0", instr, 32'h11);
    check("t1.req_low", {31'b0, mem_req}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      pc_addr = 32'(i);
      settle();
      check("t1.seq_stall", {31'b0, cache_stall}, 32'd0);
      check("t1.seq_instr", instr, 32'h11 * 32'(i + 1));
      step();
    end

    // Alternate-cycle acks on pc 36
    pc_addr = 32'd36;
    mem_ack = 1'b0;
    settle();
    check("t2.miss", {31'b0, cache_stall}, 32'd1);
    step();
    for (int k = 0; k < 8; k++) begin
      mem_ack = k[0];
      settle();
      check("t2.hold_addr", mem_addr, 32'd36 + 32'(k / 2));
      check("t2.stall", {31'b0, cache_stall}, 32'd1);
      step();
    end
    mem_ack = 1'b1;
    settle();
    check("t2.hit_stall", {31'b0, cache_stall}, 32'd0);
    check("t2.instr", instr, mem_fn(32'd36));

    // Conflict eviction: pc 64 shares index 0 with pc 0
    pc_addr = 32'd64;
    settle();
    check("t3.miss", {31'b0, cache_stall}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(); settle();
      check("t3.fill_addr", mem_addr, 32'd64 + 32'(i));
    end
    step(); settle();
    check("t3.hit", instr, mem_fn(32'd64));
    pc_addr = 32'd0;
    settle();
    check("t3.evicted", {31'b0, cache_stall}, 32'd1);
    cycles(5);

    // Flush of a valid line in LOOKUP
    pc_addr = 32'd8;
    cycles(5);
    settle();
    check("t4.hit", {31'b0, cache_stall}, 32'd0);
    flush = 1'b1;
    settle();
    check("t4.hit_during_flush", {31'b0, cache_stall}, 32'd0);
    step();
    flush = 1'b0;
    settle();
    check("t4.lost", {31'b0, cache_stall}, 32'd1);
    step(); settle();
    check("t4.refill_addr", mem_addr, 32'd8);
    check("t4.refill_req", {31'b0, mem_req}, 32'd1);
    cycles(4);

    // Flush on the 2nd ack of a fill
    pc_addr = 32'd12;
    settle();
    step(); step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step(); step();
    settle();
    check("t5.remiss", {31'b0, cache_stall}, 32'd1);
    check("t5.req_off", {31'b0, mem_req}, 32'd0);
    step(); settle();
    check("t5.refill_addr", mem_addr, 32'd12);
    cycles(4);
    settle();
    check("t5.hit", instr, mem_fn(32'd12));

    // Reset mid-fill after 2 acks
    pc_addr = 32'd200;
    step(); step(); step();
    rst_ = 1'b0;
    model_reset();
    settle();
    check("t6.abort_req", {31'b0, mem_req}, 32'd0);
    check("t6.abort_addr", mem_addr, 32'h0);
    step();
    rst_    = 1'b1;
    pc_addr = 32'd0;
    settle();
    check("t6.miss", {31'b0, cache_stall}, 32'd1);
    step(); settle();
    check("t6.fill_addr", mem_addr, 32'd0);
    check("t6.fill_req", {31'b0, mem_req}, 32'd1);
    cycles(4);
    settle();
    check("t6.hit", instr, 32'h11);

    // pc changes during a fill
    pc_addr = 32'd4;
    step();
    pc_addr = 32'd20;
    cycles(4);
    settle();
    check("t7.miss20", {31'b0, cache_stall}, 32'd1);
    step(); settle();
    check("t7.fill20", mem_addr, 32'd20);
    cycles(4);
    pc_addr = 32'd4;
    settle();
    check("t7.hit4", instr, mem_fn(32'd4));
    check("t7.hit4_stall", {31'b0, cache_stall}, 32'd0);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      if (m_filling) begin
        if ($urandom_range(0, 7) == 0) pc_addr = 32'($urandom_range(0, 383));
      end else if (m_hit(pc_addr)) begin
        if ($urandom_range(0, 49) == 0)      pc_addr = $urandom();
        else if ($urandom_range(0, 3) == 0)  pc_addr = 32'($urandom_range(0, 383));
        else                                 pc_addr = pc_addr + 1;
      end
      flush   = ($urandom_range(0, 39) == 0);
      mem_ack = ($urandom_range(0, 9) < 6);
      step();
    end
    flush = 1'b0;
    cycles(2);
    started = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
